// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: loads a byte onto the m81 data inputs and
// steps its select through all eight slots (parallel-to-serial).
module mux_sel_sequencer #(
  parameter int unsigned DIV_W     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [7:0]       load_data,
  input  logic [DIV_W-1:0] load_div,
  input  logic             abort,
  output logic [7:0]       d_out,
  output logic [2:0]       sel,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] SEL_FIRST =
    MSB_FIRST ? 3'd7 : 3'd0;

  state_t           state;
  state_t           state_n;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_n;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_n;
  logic [2:0]       bit_idx;
  logic [2:0]       idx_n;
  logic [7:0]       d_n;
  logic [2:0]       sel_n;
  logic             strobe_n;
  logic             done_n;
  logic             slot_end;
  logic             last_bit;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign slot_end   = (cnt == div_reg);
  assign last_bit   = (bit_idx == 3'd7);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state and next-datapath decode
  always_comb begin
    state_n  = state;
    d_n      = d_out;
    sel_n    = sel;
    div_n    = div_reg;
    cnt_n    = cnt;
    idx_n    = bit_idx;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_valid) begin
          d_n      = load_data;
          div_n    = load_div;
          sel_n    = SEL_FIRST;
          idx_n    = 3'd0;
          cnt_n    = '0;
          strobe_n = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (slot_end) begin
          cnt_n = '0;
          if (last_bit) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            idx_n    = bit_idx + 3'd1;
            sel_n    = MSB_FIRST ? sel - 3'd1
                                 : sel + 3'd1;
            strobe_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      DONE: begin
        if (abort) begin
          cnt_n = '0;
        end
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // datapath and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out      <= '0;
      sel        <= '0;
      div_reg    <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
    end else begin
      d_out      <= d_n;
      sel        <= sel_n;
      div_reg    <= div_n;
      cnt        <= cnt_n;
      bit_idx    <= idx_n;
      bit_strobe <= strobe_n;
      done       <= done_n;
    end
  end

endmodule
